// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM port arbiter.
package vram_arb_pkg;

    localparam int unsigned STREAK_W = 8;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned MASK_W   = 4;

    // Display reads always fetch the full word.
    localparam logic [MASK_W-1:0] M0_READ_MASK = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } grant_state_t;

endpackage

// File: rtl/vram_arbiter.sv
// Arbitrates the single VRAM port between display scanout (m0, fixed
// priority, read-only) and the rasterizer (m1, read/write). A saturating
// streak counter forces one m1 grant after MAX_M0_STREAK contended m0 grants.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned MAX_M0_STREAK = 8,
    parameter int unsigned ADDR_W        = 32
) (
    input  logic                clk,
    input  logic                reset_i,

    input  logic                m0_sel_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    output logic                m0_ack_o,
    output logic [DATA_W-1:0]   m0_data_o,

    input  logic                m1_sel_i,
    input  logic                m1_wr_i,
    input  logic [MASK_W-1:0]   m1_mask_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_data_i,
    output logic                m1_ack_o,
    output logic [DATA_W-1:0]   m1_data_o,

    output logic                vram_sel_o,
    output logic                vram_wr_o,
    output logic [MASK_W-1:0]   vram_mask_o,
    output logic [ADDR_W-1:0]   vram_addr_o,
    output logic [DATA_W-1:0]   vram_data_out_o,
    input  logic [DATA_W-1:0]   vram_data_in_i,
    input  logic                vram_ack_i,

    output logic [STREAK_W-1:0] m0_streak_o
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_M0_STREAK);

    grant_state_t        state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    // Next grant decision and streak bookkeeping on leaving IDLE.
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        case (state_q)
            IDLE: begin
                if (m0_sel_i && !(m1_sel_i && (streak_q == STREAK_MAX))) begin
                    state_d = GNT0;
                    if (m1_sel_i) begin
                        streak_d = (streak_q < STREAK_MAX) ? streak_q + STREAK_W'(1) : streak_q;
                    end else begin
                        streak_d = '0;
                    end
                end else if (m1_sel_i) begin
                    state_d  = GNT1;
                    streak_d = '0;
                end
            end
            GNT0: begin
                if (vram_ack_i) state_d = IDLE;
            end
            GNT1: begin
                if (vram_ack_i) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grant state and streak registers; reset abandons any grant in flight.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q  <= IDLE;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    // VRAM request mux and ack steering, selected by the registered grant.
    always_comb begin
        vram_sel_o      = 1'b0;
        vram_wr_o       = 1'b0;
        vram_mask_o     = '0;
        vram_addr_o     = '0;
        vram_data_out_o = '0;
        m0_ack_o        = 1'b0;
        m1_ack_o        = 1'b0;
        case (state_q)
            GNT0: begin
                vram_sel_o  = m0_sel_i;
                vram_mask_o = M0_READ_MASK;
                vram_addr_o = m0_addr_i;
                m0_ack_o    = vram_ack_i;
            end
            GNT1: begin
                vram_sel_o      = m1_sel_i;
                vram_wr_o       = m1_wr_i;
                vram_mask_o     = m1_mask_i;
                vram_addr_o     = m1_addr_i;
                vram_data_out_o = m1_data_i;
                m1_ack_o        = vram_ack_i;
            end
            default: begin
            end
        endcase
    end

    assign m0_data_o   = vram_data_in_i;
    assign m1_data_o   = vram_data_in_i;
    assign m0_streak_o = streak_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed and randomized checks for vram_arbiter.
module tb_vram_arbiter;

    localparam int unsigned MAX    = 8;
    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset_i;
    logic              m0_sel_i;
    logic [ADDR_W-1:0] m0_addr_i;
    logic              m0_ack_o;
    logic [15:0]       m0_data_o;
    logic              m1_sel_i;
    logic              m1_wr_i;
    logic [3:0]        m1_mask_i;
    logic [ADDR_W-1:0] m1_addr_i;
    logic [15:0]       m1_data_i;
    logic              m1_ack_o;
    logic [15:0]       m1_data_o;
    logic              vram_sel_o;
    logic              vram_wr_o;
    logic [3:0]        vram_mask_o;
    logic [ADDR_W-1:0] vram_addr_o;
    logic [15:0]       vram_data_out_o;
    logic [15:0]       vram_data_in_i;
    logic              vram_ack_i;
    logic [7:0]        m0_streak_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    vram_arbiter #(.MAX_M0_STREAK(MAX), .ADDR_W(ADDR_W)) dut (
        .clk             (clk),
        .reset_i         (reset_i),
        .m0_sel_i        (m0_sel_i),
        .m0_addr_i       (m0_addr_i),
        .m0_ack_o        (m0_ack_o),
        .m0_data_o       (m0_data_o),
        .m1_sel_i        (m1_sel_i),
        .m1_wr_i         (m1_wr_i),
        .m1_mask_i       (m1_mask_i),
        .m1_addr_i       (m1_addr_i),
        .m1_data_i       (m1_data_i),
        .m1_ack_o        (m1_ack_o),
        .m1_data_o       (m1_data_o),
        .vram_sel_o      (vram_sel_o),
        .vram_wr_o       (vram_wr_o),
        .vram_mask_o     (vram_mask_o),
        .vram_addr_o     (vram_addr_o),
        .vram_data_out_o (vram_data_out_o),
        .vram_data_in_i  (vram_data_in_i),
        .vram_ack_i      (vram_ack_i),
        .m0_streak_o     (m0_streak_o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [63:0] obs;
        reset_i        = 1'b1;
        m0_sel_i       = 1'b1;
        m1_sel_i       = 1'b1;
        vram_ack_i     = 1'b1;
        vram_data_in_i = 16'hBEEF;
        tick;
        tick;
        obs = {vram_sel_o, vram_wr_o, vram_mask_o, vram_addr_o, vram_data_out_o,
               m0_ack_o, m1_ack_o, m0_streak_o};
        tests_run++;
        if (obs !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        tests_run++;
        if ({m0_data_o, m1_data_o} !== 32'hBEEF_BEEF) begin
            tests_failed++;
            $display("FAIL reset_data_mirror: got %h expected beefbeef", {m0_data_o, m1_data_o});
        end
        m0_sel_i       = 1'b0;
        m1_sel_i       = 1'b0;
        vram_ack_i     = 1'b0;
        vram_data_in_i = 16'h0;
        reset_i        = 1'b0;
        tick;
    endtask

    task automatic test_m1_write;
        int n0;
        int n1;
        m1_sel_i  = 1'b1;
        m1_wr_i   = 1'b1;
        m1_addr_i = 32'h100;
        m1_data_i = 16'hABCD;
        m1_mask_i = 4'h3;
        #1;
        tests_run++;
        if (vram_sel_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL m1wr_sel_early: got %b expected 0", vram_sel_o);
        end
        tick;
        tests_run++;
        if ({vram_sel_o, vram_wr_o, vram_mask_o, vram_addr_o, vram_data_out_o} !==
            {1'b1, 1'b1, 4'h3, 32'h100, 16'hABCD}) begin
            tests_failed++;
            $display("FAIL m1wr_fields: got sel=%b wr=%b mask=%h addr=%h data=%h expected 1 1 3 100 abcd",
                     vram_sel_o, vram_wr_o, vram_mask_o, vram_addr_o, vram_data_out_o);
        end
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 6; c++) begin
            vram_ack_i = (c == 3);
            #1;
            if (m0_ack_o) n0++;
            if (m1_ack_o) n1++;
            tick;
            if (c == 3) begin
                m1_sel_i = 1'b0;
                m1_wr_i  = 1'b0;
            end
        end
        vram_ack_i = 1'b0;
        tests_run++;
        if (n1 != 1 || n0 != 0) begin
            tests_failed++;
            $display("FAIL m1wr_ack_count: got m1=%0d m0=%0d expected m1=1 m0=0", n1, n0);
        end
        #1;
        tests_run++;
        if (vram_sel_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL m1wr_idle_after: got sel=%b expected 0", vram_sel_o);
        end
    endtask

    task automatic test_m0_read;
        m0_sel_i  = 1'b1;
        m0_addr_i = 32'h2000;
        tick;
        tests_run++;
        if ({vram_sel_o, vram_wr_o, vram_mask_o, vram_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h2000}) begin
            tests_failed++;
            $display("FAIL m0rd_fields: got sel=%b wr=%b mask=%h addr=%h expected 1 0 f 2000",
                     vram_sel_o, vram_wr_o, vram_mask_o, vram_addr_o);
        end
        tick;
        vram_data_in_i = 16'h1234;
        vram_ack_i     = 1'b1;
        #1;
        tests_run++;
        if ({m0_ack_o, m0_data_o, m1_ack_o, vram_wr_o, vram_mask_o} !== {1'b1, 16'h1234, 1'b0, 1'b0, 4'hF}) begin
            tests_failed++;
            $display("FAIL m0rd_ack: got ack0=%b data=%h ack1=%b wr=%b mask=%h expected 1 1234 0 0 f",
                     m0_ack_o, m0_data_o, m1_ack_o, vram_wr_o, vram_mask_o);
        end
        tick;
        vram_ack_i     = 1'b0;
        vram_data_in_i = 16'h0;
        m0_sel_i       = 1'b0;
        #1;
        tests_run++;
        if (m0_ack_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL m0rd_single_pulse: got ack0=%b expected 0", m0_ack_o);
        end
    endtask

    task automatic test_streak;
        int          p;
        logic        exp_m1;
        logic [7:0]  exp_streak;
        logic [31:0] exp_addr;
        m0_addr_i = 32'h3000;
        m1_addr_i = 32'h4000;
        m1_wr_i   = 1'b0;
        m1_mask_i = 4'h5;
        m0_sel_i  = 1'b1;
        m1_sel_i  = 1'b1;
        for (int g = 0; g < 18; g++) begin
            tick;
            p          = g % 9;
            exp_m1     = (p == 8);
            exp_streak = exp_m1 ? 8'd0 : 8'(p + 1);
            exp_addr   = exp_m1 ? 32'h4000 : 32'h3000;
            vram_ack_i = 1'b1;
            #1;
            tests_run++;
            if ({m1_ack_o, m0_ack_o} !== {exp_m1, ~exp_m1}) begin
                tests_failed++;
                $display("FAIL streak_grant%0d: got ack1=%b ack0=%b expected ack1=%b", g, m1_ack_o, m0_ack_o, exp_m1);
            end
            tests_run++;
            if (m0_streak_o !== exp_streak) begin
                tests_failed++;
                $display("FAIL streak_count%0d: got %0d expected %0d", g, m0_streak_o, exp_streak);
            end
            tests_run++;
            if (vram_addr_o !== exp_addr) begin
                tests_failed++;
                $display("FAIL streak_addr%0d: got %h expected %h", g, vram_addr_o, exp_addr);
            end
            tick;
            vram_ack_i = 1'b0;
            if (g == 17) begin
                m0_sel_i = 1'b0;
                m1_sel_i = 1'b0;
            end
        end
        tick;
    endtask

    task automatic test_back_to_back;
        int n;
        m1_sel_i  = 1'b1;
        m1_wr_i   = 1'b1;
        m1_addr_i = 32'h500;
        m1_data_i = 16'h55AA;
        m1_mask_i = 4'hF;
        tick;
        vram_ack_i = 1'b1;
        #1;
        tests_run++;
        if (m1_ack_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_first_ack: got %b expected 1", m1_ack_o);
        end
        tick;
        vram_ack_i = 1'b0;
        n = 1;
        while (!vram_sel_o && n < 6) begin
            tick;
            n++;
        end
        tests_run++;
        if (n != 2) begin
            tests_failed++;
            $display("FAIL b2b_gap: got %0d cycles expected 2", n);
        end
        vram_ack_i = 1'b1;
        #1;
        tests_run++;
        if (m1_ack_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_second_ack: got %b expected 1", m1_ack_o);
        end
        tick;
        vram_ack_i = 1'b0;
        m1_sel_i   = 1'b0;
        m1_wr_i    = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid;
        logic [63:0] obs;
        m1_sel_i  = 1'b1;
        m1_wr_i   = 1'b1;
        m1_addr_i = 32'h777;
        m1_data_i = 16'h9999;
        m1_mask_i = 4'hC;
        tick;
        tests_run++;
        if (vram_sel_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_granted: got sel=%b expected 1", vram_sel_o);
        end
        reset_i = 1'b1;
        tick;
        obs = {vram_sel_o, vram_wr_o, vram_mask_o, vram_addr_o, vram_data_out_o,
               m0_ack_o, m1_ack_o, m0_streak_o};
        tests_run++;
        if (obs !== 64'h0) begin
            tests_failed++;
            $display("FAIL rstmid_outputs: got %h expected 0", obs);
        end
        m1_sel_i   = 1'b0;
        m1_wr_i    = 1'b0;
        vram_ack_i = 1'b1;
        #1;
        tests_run++;
        if ({m0_ack_o, m1_ack_o} !== 2'b00) begin
            tests_failed++;
            $display("FAIL rstmid_stray_ack_in_reset: got %b expected 00", {m0_ack_o, m1_ack_o});
        end
        reset_i = 1'b0;
        tick;
        tests_run++;
        if ({m0_ack_o, m1_ack_o, vram_sel_o} !== 3'b000) begin
            tests_failed++;
            $display("FAIL rstmid_stray_ack_after: got %b expected 000", {m0_ack_o, m1_ack_o, vram_sel_o});
        end
        vram_ack_i = 1'b0;
        tick;
    endtask

    task automatic test_random;
        logic        m0_pend, m1_pend, m0_drop, m1_drop, issue;
        logic [15:0] rdata;
        int          lat, req0, req1, ack0, ack1, wait0, wait1, m0_since;
        m0_pend = 0; m1_pend = 0; m0_drop = 0; m1_drop = 0;
        req0 = 0; req1 = 0; ack0 = 0; ack1 = 0; wait0 = 0; wait1 = 0; m0_since = 0;
        rdata = 16'h0;
        lat   = int'($urandom_range(0, 3));
        for (int cyc = 0; cyc < 10300; cyc++) begin
            tick;
            issue      = (cyc < 10000);
            vram_ack_i = 1'b0;
            if (m0_drop) begin
                m0_sel_i = 1'b0;
                m0_drop  = 0;
            end else if (!m0_pend && issue && $urandom_range(0, 3) != 0) begin
                m0_sel_i  = 1'b1;
                m0_addr_i = $urandom;
                m0_pend   = 1;
                wait0     = 0;
                req0++;
            end
            if (m1_drop) begin
                m1_sel_i = 1'b0;
                m1_drop  = 0;
            end else if (!m1_pend && issue && $urandom_range(0, 2) == 0) begin
                m1_sel_i  = 1'b1;
                m1_wr_i   = 1'($urandom);
                m1_mask_i = 4'($urandom);
                m1_addr_i = $urandom;
                m1_data_i = 16'($urandom);
                m1_pend   = 1;
                wait1     = 0;
                m0_since  = 0;
                req1++;
            end
            #1;
            if (vram_sel_o) begin
                if (lat == 0) begin
                    rdata          = 16'($urandom);
                    vram_data_in_i = rdata;
                    vram_ack_i     = 1'b1;
                    lat            = int'($urandom_range(0, 3));
                end else begin
                    lat--;
                end
            end
            #1;
            if (vram_ack_i && !(m0_ack_o ^ m1_ack_o)) begin
                tests_run++;
                tests_failed++;
                $display("FAIL rnd_ack_steer cyc%0d: got ack0=%b ack1=%b expected exactly one", cyc, m0_ack_o, m1_ack_o);
            end
            if (m0_ack_o) begin
                tests_run++;
                if (!m0_pend || m0_data_o !== rdata || vram_addr_o !== m0_addr_i || vram_wr_o !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rnd_m0_ack cyc%0d: got pend=%b data=%h addr=%h wr=%b expected 1 %h %h 0",
                             cyc, m0_pend, m0_data_o, vram_addr_o, vram_wr_o, rdata, m0_addr_i);
                end
                ack0++;
                m0_pend = 0;
                m0_drop = 1;
                if (m1_pend) m0_since++;
                tests_run++;
                if (m0_since > int'(MAX) + 1) begin
                    tests_failed++;
                    $display("FAIL rnd_starve cyc%0d: got %0d m0 grants while m1 waits, limit %0d", cyc, m0_since, MAX + 1);
                end
            end
            if (m1_ack_o) begin
                tests_run++;
                if (!m1_pend || m1_data_o !== rdata || vram_addr_o !== m1_addr_i ||
                    vram_wr_o !== m1_wr_i || vram_data_out_o !== m1_data_i || vram_mask_o !== m1_mask_i) begin
                    tests_failed++;
                    $display("FAIL rnd_m1_ack cyc%0d: got pend=%b data=%h addr=%h wr=%b expected 1 %h %h %b",
                             cyc, m1_pend, m1_data_o, vram_addr_o, vram_wr_o, rdata, m1_addr_i, m1_wr_i);
                end
                ack1++;
                m1_pend  = 0;
                m1_drop  = 1;
                m0_since = 0;
            end
            if (m0_pend) wait0++;
            if (m1_pend) wait1++;
            if (wait0 == 200 || wait1 == 200) begin
                tests_run++;
                tests_failed++;
                $display("FAIL rnd_timeout cyc%0d: got wait0=%0d wait1=%0d expected below 200", cyc, wait0, wait1);
            end
        end
        tick;
        m0_sel_i   = 1'b0;
        m1_sel_i   = 1'b0;
        vram_ack_i = 1'b0;
        tests_run++;
        if (req0 != ack0 || req1 != ack1 || req0 == 0 || req1 == 0) begin
            tests_failed++;
            $display("FAIL rnd_ack_totals: got acks %0d/%0d expected requests %0d/%0d", ack0, ack1, req0, req1);
        end
        tick;
    endtask

    initial begin
        reset_i        = 1'b1;
        m0_sel_i       = 1'b0;
        m0_addr_i      = '0;
        m1_sel_i       = 1'b0;
        m1_wr_i        = 1'b0;
        m1_mask_i      = 4'h0;
        m1_addr_i      = '0;
        m1_data_i      = 16'h0;
        vram_data_in_i = 16'h0;
        vram_ack_i     = 1'b0;
        test_reset;
        test_m1_write;
        test_m0_read;
        test_streak;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
